// File: rtl/hyperbus_phy_ctrl.sv
// rtl/hyperbus_phy_ctrl.sv - HyperBus transaction sequencer driving the transceiver controls
module hyperbus_phy_ctrl #(
    parameter int  NumChips     = 2,
    parameter int  BurstWidth   = 16,
    parameter int  TimeoutWidth = 8,
    localparam int CsWidth      = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [3:0]              cfg_latency_i,
    input  logic [3:0]              cfg_t_csh_i,
    input  logic [3:0]              cfg_t_rwr_i,
    input  logic [TimeoutWidth-1:0] cfg_timeout_i,
    input  logic                    trans_valid_i,
    output logic                    trans_ready_o,
    input  logic                    trans_write_i,
    input  logic [31:0]             trans_addr_i,
    input  logic [BurstWidth-1:0]   trans_burst_i,
    input  logic [CsWidth-1:0]      trans_cs_i,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  logic [15:0]             tx_data_i,
    input  logic [1:0]              tx_strb_i,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output logic [15:0]             rx_data_o,
    output logic                    rx_last_o,
    output logic                    rx_error_o,
    output logic                    b_valid_o,
    output logic [NumChips-1:0]     trx_cs_o,
    output logic                    trx_cs_ena_o,
    output logic                    trx_tx_clk_ena_o,
    output logic [15:0]             trx_tx_data_o,
    output logic                    trx_tx_data_oe_o,
    output logic [1:0]              trx_tx_rwds_o,
    output logic                    trx_tx_rwds_oe_o,
    input  logic                    trx_rwds_sample_i,
    output logic                    trx_rwds_sample_ena_o,
    output logic                    trx_rx_clk_set_o,
    output logic                    trx_rx_clk_reset_o,
    input  logic [15:0]             trx_rx_data_i,
    input  logic                    trx_rx_valid_i,
    output logic                    trx_rx_ready_o
);
    typedef enum logic [2:0] {IDLE, CMD, LAT, WRITE, READ, HOLD, RECOVER} state_e;
    state_e state_q, state_d;

    logic                    write_q, rwds_q, tmo_q;
    logic [31:0]             addr_q;
    logic [CsWidth-1:0]      cs_q;
    logic [BurstWidth-1:0]   words_left_q, clk_left_q, burst_eff;
    logic [TimeoutWidth-1:0] tmo_cnt_q;
    logic [7:0]              cnt_q, lat_len;
    logic [3:0]              lat_eff, csh_eff, rwr_eff;
    logic [47:0]             ca;
    logic cmd_last, lat_last, hold_last, rec_last;
    logic tmo_hit, err_active, rx_word, read_done;

    assign lat_eff   = (cfg_latency_i == 4'd0) ? 4'd1 : cfg_latency_i;
    assign csh_eff   = (cfg_t_csh_i == 4'd0) ? 4'd1 : cfg_t_csh_i;
    assign rwr_eff   = (cfg_t_rwr_i == 4'd0) ? 4'd1 : cfg_t_rwr_i;
    assign burst_eff = (trans_burst_i == '0) ? BurstWidth'(1) : trans_burst_i;
    // A high RWDS during CA signals the device needs the doubled initial latency
    assign lat_len   = rwds_q ? {3'b0, lat_eff, 1'b0} : {4'b0, lat_eff};

    assign cmd_last  = (cnt_q == 8'd2);
    assign lat_last  = (cnt_q == lat_len - 8'd1);
    assign hold_last = (cnt_q == {4'b0, csh_eff} - 8'd1);
    assign rec_last  = (cnt_q == {4'b0, rwr_eff} - 8'd1);
    assign ca        = {~write_q, 1'b0, 1'b1, addr_q[31:3], 13'b0, addr_q[2:0]};

    // Once the timeout fires, the error word is held until the consumer takes it
    assign tmo_hit    = (state_q == READ) && !tmo_q && !trx_rx_valid_i && (cfg_timeout_i != '0)
                        && ((tmo_cnt_q + TimeoutWidth'(1)) == cfg_timeout_i);
    assign err_active = tmo_q || tmo_hit;
    assign rx_word    = (state_q == READ) && !tmo_q && trx_rx_valid_i;
    assign read_done  = (rx_word && rx_ready_i && (words_left_q == BurstWidth'(1)))
                        || (err_active && rx_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trans_valid_i) state_d = CMD;
            CMD:     if (cmd_last) state_d = LAT;
            LAT:     if (lat_last) state_d = write_q ? WRITE : READ;
            WRITE:   if (tx_valid_i && (words_left_q == BurstWidth'(1))) state_d = HOLD;
            READ:    if (read_done) state_d = HOLD;
            HOLD:    if (hold_last) state_d = RECOVER;
            RECOVER: if (rec_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            cs_q         <= '0;
            rwds_q       <= 1'b0;
            words_left_q <= '0;
            clk_left_q   <= '0;
            tmo_cnt_q    <= '0;
            tmo_q        <= 1'b0;
        end else begin
            cnt_q     <= ((state_d != state_q) || (state_q == IDLE)) ? 8'd0 : cnt_q + 8'd1;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trans_valid_i) begin
                        write_q      <= trans_write_i;
                        addr_q       <= trans_addr_i;
                        cs_q         <= trans_cs_i;
                        words_left_q <= burst_eff;
                        clk_left_q   <= burst_eff;
                    end
                end
                CMD: begin
                    if (cmd_last) rwds_q <= trx_rwds_sample_i;
                end
                WRITE: begin
                    if (tx_valid_i) words_left_q <= words_left_q - BurstWidth'(1);
                end
                READ: begin
                    if (clk_left_q != '0) clk_left_q <= clk_left_q - BurstWidth'(1);
                    if (rx_word && rx_ready_i) words_left_q <= words_left_q - BurstWidth'(1);
                    tmo_cnt_q <= trx_rx_valid_i ? '0 : tmo_cnt_q + TimeoutWidth'(1);
                    tmo_q     <= err_active && !rx_ready_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        trans_ready_o         = 1'b0;
        tx_ready_o            = 1'b0;
        rx_valid_o            = 1'b0;
        rx_data_o             = '0;
        rx_last_o             = 1'b0;
        rx_error_o            = 1'b0;
        b_valid_o             = 1'b0;
        trx_cs_ena_o          = 1'b0;
        trx_tx_clk_ena_o      = 1'b0;
        trx_tx_data_o         = '0;
        trx_tx_data_oe_o      = 1'b0;
        trx_tx_rwds_o         = '0;
        trx_tx_rwds_oe_o      = 1'b0;
        trx_rwds_sample_ena_o = 1'b0;
        trx_rx_clk_set_o      = 1'b0;
        trx_rx_clk_reset_o    = 1'b0;
        trx_rx_ready_o        = 1'b1;
        case (state_q)
            IDLE: trans_ready_o = rst_ni;
            CMD: begin
                trx_cs_ena_o          = 1'b1;
                trx_tx_clk_ena_o      = 1'b1;
                trx_tx_data_oe_o      = 1'b1;
                trx_rwds_sample_ena_o = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    trx_tx_data_o = ca[47:32];
                    2'd1:    trx_tx_data_o = ca[31:16];
                    default: trx_tx_data_o = ca[15:0];
                endcase
            end
            LAT: begin
                trx_cs_ena_o     = 1'b1;
                trx_tx_clk_ena_o = 1'b1;
                if (lat_last) begin
                    trx_tx_data_oe_o = write_q;
                    trx_tx_rwds_oe_o = write_q;
                    trx_rx_clk_set_o = !write_q;
                end
            end
            WRITE: begin
                trx_cs_ena_o     = 1'b1;
                trx_tx_data_oe_o = 1'b1;
                trx_tx_rwds_oe_o = 1'b1;
                tx_ready_o       = tx_valid_i;
                trx_tx_clk_ena_o = tx_valid_i;
                if (tx_valid_i) begin
                    trx_tx_data_o = tx_data_i;
                    trx_tx_rwds_o = ~tx_strb_i;
                end
            end
            READ: begin
                trx_cs_ena_o       = 1'b1;
                trx_tx_clk_ena_o   = (clk_left_q != '0);
                trx_rx_ready_o     = rx_ready_i;
                rx_valid_o         = trx_rx_valid_i || err_active;
                rx_data_o          = err_active ? 16'h0000 : trx_rx_data_i;
                rx_error_o         = err_active;
                rx_last_o          = err_active || (trx_rx_valid_i && (words_left_q == BurstWidth'(1)));
                trx_rx_clk_reset_o = read_done;
            end
            HOLD: begin
                trx_cs_ena_o = 1'b1;
                b_valid_o    = hold_last && write_q;
            end
            default: ;
        endcase
        trx_cs_o = trx_cs_ena_o ? (NumChips'(1) << cs_q) : '0;
    end
endmodule
